// File: rtl/shift_sequencer.sv
// Command sequencer in front of a bit-cell shift chain: one-cycle parallel load followed by
// a programmed number of shift strobes, each preceded by `div` idle cycles.
module shift_sequencer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4,
    parameter int unsigned DIV_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic [CNT_W-1:0] nshift,
    input  logic [DIV_W-1:0] div,
    input  logic [1:0]       mode,
    input  logic             data_valid,
    output logic             data_ready,
    input  logic             q_msb,
    input  logic             q_lsb,
    output logic [WIDTH-1:0] load_val,
    output logic             load_n,
    output logic             shift,
    output logic             in_bit,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {StIdle, StLoad, StWait, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] word_q;
    logic [CNT_W-1:0] nshift_q, rem_q;
    logic [DIV_W-1:0] div_q, dcnt_q;
    logic [1:0]       mode_q;
    logic             load_n_q, shift_q, busy_q, done_q, ready_q;
    logic             fill;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (data_valid) state_d = StLoad;
            StLoad: begin
                if (nshift_q == '0)     state_d = StDone;
                else if (div_q == '0)   state_d = StShift;
                else                    state_d = StWait;
            end
            StWait:  if (dcnt_q == DIV_W'(1)) state_d = StShift;
            StShift: begin
                if (rem_q == CNT_W'(1)) state_d = StDone;
                else if (div_q == '0)   state_d = StShift;
                else                    state_d = StWait;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            word_q   <= '0;
            nshift_q <= '0;
            div_q    <= '0;
            mode_q   <= '0;
            rem_q    <= '0;
            dcnt_q   <= '0;
            load_n_q <= 1'b1;
            shift_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            load_n_q <= (state_d != StLoad);
            shift_q  <= (state_d == StShift);
            busy_q   <= (state_d != StIdle);
            done_q   <= (state_d == StDone);
            ready_q  <= (state_d == StIdle);
            unique case (state_q)
                StIdle: begin
                    if (data_valid) begin
                        word_q   <= data_in;
                        nshift_q <= nshift;
                        div_q    <= div;
                        mode_q   <= mode;
                    end
                end
                StLoad: begin
                    rem_q  <= nshift_q;
                    dcnt_q <= div_q;
                end
                StWait:  dcnt_q <= dcnt_q - DIV_W'(1);
                StShift: begin
                    rem_q  <= rem_q - CNT_W'(1);
                    dcnt_q <= div_q;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        fill = 1'b0;
        unique case (mode_q)
            2'b00: fill = 1'b0;
            2'b01: fill = q_msb;
            2'b10: fill = q_lsb;
            2'b11: fill = 1'b1;
            default: fill = 1'b0;
        endcase
    end

    assign in_bit     = shift_q & fill;
    assign load_val   = word_q;
    assign load_n     = load_n_q;
    assign shift      = shift_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign data_ready = ready_q;

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Control stage directly upstream of the bit-cell shift register chain. Accepts a parallel word and a shift command over a valid/ready handshake, drives the chain's `load_val`/`load_n` for a one-cycle parallel load, then issues a programmed number of `shift` strobes at a programmable rate. It supplies the serial fill bit into the chain's MSB cell (logical, arithmetic, rotate or ones fill) and pulses `done` when the command completes.

## Interface

- `WIDTH`, 8: chain length in bits.
- `CNT_W`, 4: width of shift-count field.
- `DIV_W`, 4: width of rate-divider field.

- `clk`  in  1  system clock; all state changes on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `data_in`  in  WIDTH  word to load into the chain.
- `nshift`  in  CNT_W  number of shift strobes to issue (0 = load only).
- `div`  in  DIV_W  idle cycles inserted before each shift strobe.
- `mode`  in  2  fill select: 00 zero, 01 arithmetic (`q_msb`), 10 rotate (`q_lsb`), 11 one.
- `data_valid`  in  1  command present.
- `data_ready`  out  1  sequencer can accept a command.
- `q_msb`  in  1  current MSB cell output of the chain.
- `q_lsb`  in  1  current LSB cell output of the chain (serial out).
- `load_val`  out  WIDTH  parallel load value to the cells.
- `load_n`  out  1  active-low load to every cell.
- `shift`  out  1  shift enable to every cell.
- `in_bit`  out  1  serial input to the MSB cell.
- `busy`  out  1  command in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation

- States: IDLE, LOAD, WAIT, SHIFT, DONE. All outputs are Moore, decoded from state and captured registers. `in_bit` is the exception: it is combinational from `mode`/`q_msb`/`q_lsb`, but only while in SHIFT.
- IDLE: `data_ready`=1.
  - On `data_valid`&&`data_ready`, capture `data_in`, `nshift`, `div`, `mode`; go to LOAD.
- LOAD, exactly one cycle:
  - `load_n`=0 and `load_val` = captured word.
  - If captured `nshift`==0, go to DONE.
  - Otherwise load the remaining counter with `nshift` and the divider counter with `div`. If `div`==0 go to SHIFT, else go to WAIT.
- WAIT:
  - Divider decrements each cycle.
  - When the divider reads 1, go to SHIFT.
- SHIFT, one cycle:
  - `shift`=1 and `in_bit` = fill per `mode`. Remaining decrements.
  - If remaining was 1, go to DONE.
  - Otherwise reload the divider with `div`, then go to WAIT, or straight back to SHIFT if `div`==0.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Output values:
  - `busy`=1 in every state except IDLE.
  - `load_n`=1 outside LOAD; `shift`=0 outside SHIFT; `in_bit`=0 outside SHIFT.
  - `load_n`=0 and `shift`=1 are never asserted together.
  - `load_val` holds the last captured word.
- Boundary conditions:
  - `nshift` larger than `WIDTH` is legal. Logical fill then yields all zeros; rotate wraps.
  - Commands presented while busy are not accepted (`data_ready`=0). `data_valid` must be held until accepted.
  - Captured fields are frozen for the command; input changes mid-command are ignored.
- Reset, asserted at any time including mid-command:
  - Forces state to IDLE.
  - Outputs: `load_n`=1, `shift`=0, `in_bit`=0, `done`=0, `busy`=0, `load_val`=0.
  - Counters are cleared and the in-flight command is discarded.
  - `data_valid` is ignored while `reset_n`=0.

## Timing

- Handshake accepted at edge k. LOAD occupies cycle k→k+1, and the chain captures the word at edge k+1.
- Each shift costs `div`+1 cycles; the first shift strobe occupies cycle k+1+`div`.
- `done` occupies the cycle after the last SHIFT, or the cycle after LOAD when `nshift`=0.
- Accept-to-`done` latency: 1 + `nshift`×(`div`+1) cycles.
- `data_ready` returns to 1 the cycle after `done`.
- Back-to-back command throughput: one command every 3 + `nshift`×(`div`+1) cycles, counting the accept cycle in IDLE.
- For arithmetic and rotate modes, `q_msb`/`q_lsb` are sampled in the SHIFT cycle. The chain must present registered cell outputs, so no combinational loop exists.

## Test plan

- Reset check:
  - Stimulus: assert `reset_n`=0, then release; then 0x96, `nshift`=3, `div`=0, mode 00.
  - Response: while reset is held, `load_n`=1, `shift`=0, `busy`=0, `done`=0, `data_ready`=1. Then `load_n` is low for 1 cycle, `shift` is high for 3 consecutive cycles with `in_bit`=0, `done` pulses on cycle 5, and the chain holds 0x12.
- Arithmetic shift:
  - Stimulus: 0x96, mode 01, `nshift`=2, `div`=0.
  - Response: `in_bit`=1 on both strobes; chain = 0xE5.
- Rotate with divider:
  - Stimulus: 0x96, mode 10, `nshift`=1, `div`=2.
  - Response: `shift` rises 3 cycles after LOAD; chain = 0x4B; `done` occurs 5 cycles after accept.
- Zero count, then busy rejection:
  - Stimulus: `nshift`=0, mode 11, 0xA5; then hold a second command on `data_valid` during the first.
  - Response: load only, chain = 0xA5, `done` the cycle after LOAD, no `shift`. The second command is accepted only after `data_ready` returns.
- Reset mid-command:
  - Stimulus: assert `reset_n` low during the 2nd WAIT of a `nshift`=4, `div`=3 command.
  - Response: `shift`/`load_n` deassert immediately, no `done`, IDLE with `data_ready`=1. The next command runs normally.
